// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches in one registered cycle
// and trains a table of 2-bit saturating predictor counters.
// Optional feature macro: BRU_STATS_EN adds the stat_branches and
// stat_mispredicts counters.

// One 2-bit saturating predictor counter.
module bru_ctr #(
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] ctr
);
    // Saturating up/down count; reset loads the configured initial state.
    always_ff @(posedge clk) begin
        if (rst)
            ctr <= CTR_INIT;
        else if (inc && ctr != 2'b11)
            ctr <= ctr + 2'd1;
        else if (dec && ctr != 2'b00)
            ctr <= ctr - 2'd1;
    end
endmodule

module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [4:0]      res_opcode,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic            res_pred,
    output logic            res_done,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [4:0] {
        OP_BEQ  = 5'b00000,
        OP_BNE  = 5'b00001,
        OP_BLT  = 5'b00100,
        OP_BGE  = 5'b00101,
        OP_BLTU = 5'b00110,
        OP_BGEU = 5'b00111
    } br_op_e;

    typedef struct packed {
        logic taken;
        logic mispredict;
        logic illegal;
    } res_t;

    logic [BHT_DEPTH-1:0][1:0] ctrs;
    logic [IDX_W-1:0]          pred_idx;
    logic [IDX_W-1:0]          res_idx;
    logic [BHT_DEPTH-1:0]      upd_sel;
    logic                      taken_c;
    logic                      illegal_c;
    logic                      eq_c;
    logic                      lt_s_c;
    logic                      lt_u_c;
    logic                      upd_en;
    res_t                      res_c;
    res_t                      res_q;
    logic                      done_q;

    // Word-aligned index; bits above the table and the byte offset alias.
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    // Read is taken from the current (pre-update) register value, so a same-
    // cycle resolve to the same entry is only visible on the next cycle.
    assign pred_taken = ctrs[pred_idx][1];

    assign eq_c   = (res_rs1 == res_rs2);
    assign lt_s_c = ($signed(res_rs1) < $signed(res_rs2));
    assign lt_u_c = (res_rs1 < res_rs2);

    // Opcode decode and outcome evaluation.
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (res_opcode)
            OP_BEQ:  taken_c = eq_c;
            OP_BNE:  taken_c = ~eq_c;
            OP_BLT:  taken_c = lt_s_c;
            OP_BGE:  taken_c = ~lt_s_c;
            OP_BLTU: taken_c = lt_u_c;
            OP_BGEU: taken_c = ~lt_u_c;
            default: illegal_c = 1'b1;
        endcase
    end

    // Response fields; idle cycles and illegal opcodes report not-taken.
    always_comb begin
        res_c            = '0;
        res_c.taken      = res_valid & taken_c;
        res_c.mispredict = res_valid & ~illegal_c & (taken_c ^ res_pred);
        res_c.illegal    = res_valid & illegal_c;
    end

    // Reset takes priority inside each counter, so a resolve during reset
    // never trains the table.
    assign upd_en  = res_valid & ~illegal_c;
    assign upd_sel = upd_en ? (BHT_DEPTH'(1) << res_idx) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            bru_ctr #(.CTR_INIT(CTR_INIT)) u_ctr (
                .clk (clk),
                .rst (rst),
                .inc (upd_sel[gi] & taken_c),
                .dec (upd_sel[gi] & ~taken_c),
                .ctr (ctrs[gi])
            );
        end
    endgenerate

    // Single-stage result register; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= res_valid;
            res_q  <= res_c;
        end
    end

    assign res_done       = done_q;
    assign res_taken      = res_q.taken;
    assign res_mispredict = res_q.mispredict;
    assign res_illegal    = res_q.illegal;

`ifdef BRU_STATS_EN
    // Free-running event counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_en)
                stat_branches <= stat_branches + 32'd1;
            if (res_c.mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width; SHALL be >= 8.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit predictor counters; SHALL be a power of 2, >= 2.
REQ-003 Parameter CTR_INIT, default 2'b01: counter value after reset (weakly not-taken).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pred_pc  in  XLEN  PC of the branch being fetched, for lookup.
REQ-007 pred_taken  out  1  combinational prediction for pred_pc.
REQ-008 res_valid  in  1  resolve request this cycle.
REQ-009 res_opcode  in  5  branch type: 00000 BEQ, 00001 BNE, 00100 BLT, 00101 BGE, 00110 BLTU, 00111 BGEU.
REQ-010 res_pc  in  XLEN  PC of the branch being resolved.
REQ-011 res_rs1, res_rs2  in  XLEN each  compare operands.
REQ-012 res_pred  in  1  prediction previously issued for this branch.
REQ-013 res_done  out  1  registered; high for one cycle, one cycle after an accepted res_valid.
REQ-014 res_taken  out  1  registered actual outcome.
REQ-015 res_mispredict  out  1  registered; res_taken != res_pred.
REQ-016 res_illegal  out  1  registered; res_opcode not in the REQ-009 list.

Function
REQ-017 Index = pc[1+log2(BHT_DEPTH):2] for both pred_pc and res_pc; upper and lower bits SHALL be ignored.
REQ-018 pred_taken SHALL equal bit 1 of the counter at the pred_pc index.
REQ-019 BEQ/BNE: equality across all XLEN bits; BLT/BGE: two's-complement signed compare; BLTU/BGEU: unsigned compare.
REQ-020 Latency: res_valid at cycle N SHALL produce res_done, res_taken, res_mispredict and res_illegal at cycle N+1; a new request SHALL be accepted every cycle, with no backpressure.
REQ-021 When res_valid is low, res_done SHALL be 0 next cycle; res_taken, res_mispredict and res_illegal SHALL be 0 in that cycle.
REQ-022 Counter update on a legal resolve: taken increments, not taken decrements; the counter SHALL saturate at 2'b11 and 2'b00, with no wrap.
REQ-023 Illegal opcode: res_taken=0, res_mispredict=0, res_illegal=1, res_done=1; no counter update.
REQ-024 When pred_pc and res_pc map to the same index in one cycle, pred_taken SHALL reflect the pre-update counter (read-before-write).
REQ-025 Only one counter SHALL change per cycle; all other counters SHALL hold.

Reset
REQ-026 While rst is high at a clock edge, every counter SHALL load CTR_INIT, and res_done, res_taken, res_mispredict and res_illegal SHALL load 0.
REQ-027 res_valid during a reset cycle SHALL be ignored: no counter update and no res_done afterwards.
REQ-028 A request accepted in the cycle before rst rises SHALL still be overwritten by reset; its outputs are discarded.
REQ-029 pred_taken SHALL reflect CTR_INIT bit 1 in the first cycle after reset.

Configuration
REQ-030 Macro BRU_STATS_EN, when defined, SHALL add outputs stat_branches (out, 32) and stat_mispredicts (out, 32).
REQ-031 With BRU_STATS_EN defined:
- stat_branches increments on each legal accepted resolve.
- stat_mispredicts increments on each mispredict.
- Both counters are cleared by rst and wrap modulo 2^32.
REQ-032 Without BRU_STATS_EN, the stat ports and their counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 After reset, BLT with rs1=0xFFFFFFFF, rs2=0x00000001, res_pred=0 -> next cycle res_done=1, res_taken=1, res_mispredict=1.
REQ-034 BLTU with rs1=0xFFFFFFFF, rs2=0x00000001, res_pred=0 -> res_taken=0, res_mispredict=0.
REQ-035 Four taken BEQ resolves at res_pc=0x40 -> pred_taken at pred_pc=0x40 goes 0,1,1,1 after updates 1-3, and the counter saturates at 2'b11; pred_pc=0x140 (same index with DEPTH=64) predicts identically.
REQ-036 Opcode 5'b00010 with res_valid=1 -> res_illegal=1, res_taken=0, and pred_taken for that PC unchanged.
REQ-037 In one cycle, res_valid=1 taken at 0x80 and pred_pc=0x80 with counter=01 -> pred_taken=0 that cycle, 1 the next.
REQ-038 rst asserted in the cycle after res_valid -> res_done=0; with BRU_STATS_EN, stat_branches=0.
